// File: rtl/debug_command_fsm_pkg.sv
// Shared constants and state encoding for the debug command FSM and its helpers.
package debug_command_fsm_pkg;

    localparam int unsigned DefUartBits        = 8;
    localparam int unsigned DefInstructionBits = 32;
    localparam int unsigned DefInstAddrsBits   = 8;

    localparam logic [7:0] CmdLoadDef  = 8'h4C;  // 'L'
    localparam logic [7:0] CmdRunDef   = 8'h43;  // 'C'
    localparam logic [7:0] CmdStepDef  = 8'h53;  // 'S'
    localparam logic [7:0] CmdResetDef = 8'h52;  // 'R'

    // Encoding is visible on o_state (LEDs), so keep the numbering stable.
    typedef enum logic [3:0] {
        StIdle      = 4'd0,
        StLoadCount = 4'd1,
        StLoadByte  = 4'd2,
        StWriteInst = 4'd3,
        StRun       = 4'd4,
        StStep      = 4'd5,
        StProcReset = 4'd6,
        StSendStart = 4'd7,
        StWaitSend  = 4'd8
    } state_e;

endpackage

// File: rtl/debug_command_fsm_uart_word_assembler.sv
// Packs consecutive UART bytes MSB-first into one word; pulses o_word_valid on the last byte.
module uart_word_assembler #(
    parameter int unsigned UART_BITS = 8,
    parameter int unsigned WORD_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clear,
    input  logic                 i_valid,
    input  logic [UART_BITS-1:0] i_byte,
    output logic [WORD_BITS-1:0] o_word,
    output logic                 o_word_valid
);

    localparam int unsigned NumBytes = WORD_BITS / UART_BITS;
    localparam int unsigned CntW     = (NumBytes > 1) ? $clog2(NumBytes) : 1;

    logic [WORD_BITS-1:0] word_q, word_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 last_byte;

    assign last_byte = (cnt_q == CntW'(NumBytes - 1));

    // Shift in a byte and advance the byte counter, wrapping after a full word.
    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_valid) begin
            word_d = {word_q[WORD_BITS-UART_BITS-1:0], i_byte};
            cnt_d  = last_byte ? '0 : cnt_q + 1'b1;
        end
    end

    // Word and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    assign o_word       = word_q;
    assign o_word_valid = i_valid && !i_clear && last_byte;

endmodule

// File: rtl/debug_command_fsm.sv
// Decodes UART command bytes: loads program words, runs/steps/resets the core, triggers dumps.
module debug_command_fsm
    import debug_command_fsm_pkg::*;
#(
    parameter int unsigned          UART_BITS        = DefUartBits,
    parameter int unsigned          INSTRUCTION_BITS = DefInstructionBits,
    parameter int unsigned          INST_ADDRS_BITS  = DefInstAddrsBits,
    parameter logic [UART_BITS-1:0] CMD_LOAD         = CmdLoadDef,
    parameter logic [UART_BITS-1:0] CMD_RUN          = CmdRunDef,
    parameter logic [UART_BITS-1:0] CMD_STEP         = CmdStepDef,
    parameter logic [UART_BITS-1:0] CMD_RESET        = CmdResetDef
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_rx_done,
    input  logic [UART_BITS-1:0]        i_rx_data,
    input  logic                        i_halt,
    input  logic                        i_send_done,
    output logic                        o_inst_wr_en,
    output logic [INST_ADDRS_BITS-1:0]  o_inst_wr_addr,
    output logic [INSTRUCTION_BITS-1:0] o_inst_wr_data,
    output logic                        o_proc_enable,
    output logic                        o_proc_reset,
    output logic                        o_send_start,
    output logic                        o_program_loaded,
    output logic [3:0]                  o_state
);

    state_e                     state_q, state_d;
    logic [INST_ADDRS_BITS-1:0] addr_q, addr_d;
    logic [UART_BITS-1:0]       count_q, count_d;
    logic                       loaded_q, loaded_d;
    logic                       word_valid;
    logic [INSTRUCTION_BITS-1:0] word;

    // Only bytes received while collecting a word reach the assembler.
    uart_word_assembler #(
        .UART_BITS (UART_BITS),
        .WORD_BITS (INSTRUCTION_BITS)
    ) u_word_assembler (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (state_q == StIdle),
        .i_valid      (i_rx_done && (state_q == StLoadByte)),
        .i_byte       (i_rx_data),
        .o_word       (word),
        .o_word_valid (word_valid)
    );

    // Next-state, load address, remaining-word count and program-present flag.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        count_d  = count_q;
        loaded_d = loaded_q;
        unique case (state_q)
            StIdle: begin
                if (i_rx_done) begin
                    if (i_rx_data == CMD_LOAD) begin
                        state_d  = StLoadCount;
                        loaded_d = 1'b0;
                        addr_d   = '0;
                    end else if (i_rx_data == CMD_RUN && loaded_q) begin
                        state_d = StRun;
                    end else if (i_rx_data == CMD_STEP && loaded_q) begin
                        state_d = StStep;
                    end else if (i_rx_data == CMD_RESET) begin
                        state_d = StProcReset;
                    end
                end
            end
            StLoadCount: begin
                if (i_rx_done) begin
                    if (i_rx_data == '0) begin
                        state_d  = StIdle;
                        loaded_d = 1'b1;
                    end else begin
                        count_d = i_rx_data;
                        state_d = StLoadByte;
                    end
                end
            end
            StLoadByte: begin
                if (word_valid) state_d = StWriteInst;
            end
            StWriteInst: begin
                addr_d  = addr_q + 1'b1;
                count_d = count_q - 1'b1;
                if (count_q == UART_BITS'(1)) begin
                    state_d  = StIdle;
                    loaded_d = 1'b1;
                end else begin
                    state_d = StLoadByte;
                end
            end
            // A byte arriving in the halt cycle is simply never looked at.
            StRun: begin
                if (i_halt) state_d = StSendStart;
            end
            StStep:      state_d = StSendStart;
            StProcReset: state_d = StIdle;
            StSendStart: state_d = StWaitSend;
            StWaitSend: begin
                if (i_send_done) state_d = StIdle;
            end
            default:     state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            count_q  <= '0;
            loaded_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            count_q  <= count_d;
            loaded_q <= loaded_d;
        end
    end

    assign o_inst_wr_en     = (state_q == StWriteInst);
    assign o_inst_wr_addr   = addr_q;
    assign o_inst_wr_data   = word;
    // Gated by halt directly so the core never gets an extra cycle after HALT.
    assign o_proc_enable    = ((state_q == StRun) || (state_q == StStep)) && !i_halt;
    assign o_proc_reset     = (state_q == StProcReset);
    assign o_send_start     = (state_q == StSendStart);
    assign o_program_loaded = loaded_q;
    assign o_state          = state_q;

endmodule
